// File: rtl/mips_mem_pkg.sv
// Shared widths and enumerations for the instruction/data memory port arbiter.
// The owner type records which requester the outstanding memory access belongs to.
package mips_mem_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with a
// fixed read latency; one transaction in flight, starvation-limited data priority.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LOAD   = 3'(LATENCY - 1);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_t r_state, w_state_next;
  owner_t     r_owner, w_owner_next;
  logic [2:0] r_lat_cnt, w_lat_cnt_next;
  logic [2:0] r_starve_cnt, w_starve_cnt_next;
  logic       w_done;
  logic       w_free;
  logic       w_grant_if;
  logic       w_grant_d;

  // The response cycle doubles as an idle cycle so a new grant can overlap it.
  assign w_done = (r_state == ST_BUSY) && (r_lat_cnt == 3'd0);
  assign w_free = (r_state == ST_IDLE) || w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 3'd0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_lat_cnt    <= w_lat_cnt_next;
      r_starve_cnt <= w_starve_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_lat_cnt_next    = r_lat_cnt;
    w_starve_cnt_next = r_starve_cnt;
    w_grant_if        = 1'b0;
    w_grant_d         = 1'b0;

    if (w_free) begin
      if (if_req && (!d_req || (r_starve_cnt >= STARVE_LIM))) begin
        w_grant_if = 1'b1;
      end else if (d_req) begin
        w_grant_d = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_grant_if || w_grant_d) begin
          w_state_next   = ST_BUSY;
          w_lat_cnt_next = LAT_LOAD;
          w_owner_next   = w_grant_d ? OWN_D : OWN_IF;
        end
      end
      ST_BUSY: begin
        if (w_grant_if || w_grant_d) begin
          w_lat_cnt_next = LAT_LOAD;
          w_owner_next   = w_grant_d ? OWN_D : OWN_IF;
        end else if (w_done) begin
          w_state_next = ST_IDLE;
        end else begin
          w_lat_cnt_next = r_lat_cnt - 3'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Counts losses only when data actually takes the port from a waiting fetch.
    if (w_grant_if) begin
      w_starve_cnt_next = 3'd0;
    end else if (if_req && w_grant_d && (r_starve_cnt != 3'd7)) begin
      w_starve_cnt_next = r_starve_cnt + 3'd1;
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if_gnt = w_grant_if;
      d_gnt  = w_grant_d;
      mem_en = w_grant_if || w_grant_d;
      if (w_grant_if) begin
        mem_addr = if_addr;
      end else if (w_grant_d) begin
        mem_addr  = d_addr;
        mem_we    = d_we;
        mem_wdata = d_wdata;
      end
    end
  end

  assign if_rvalid = w_done && (r_owner == OWN_IF);
  assign d_rvalid  = w_done && (r_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2: memory read latency in cycles, legal range 1..7.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive fetch losses before fetch is forced to win, legal range 1..7.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  fetch request, held until if_gnt.
REQ-006 if_addr  in  30  fetch word address.
REQ-007 if_gnt  out  1  fetch accepted this cycle.
REQ-008 if_rvalid  out  1  fetch data valid pulse.
REQ-009 if_rdata  out  32  fetch read data.
REQ-010 d_req  in  1  data request, held until d_gnt.
REQ-011 d_we, d_addr, d_wdata  in  1/30/32  write enable, word address, write data.
REQ-012 d_gnt, d_rvalid  out  1/1  data accepted; read-data-valid or write-ack pulse.
REQ-013 d_rdata  out  32  data read data.
REQ-014 mem_en, mem_we, mem_addr, mem_wdata  out  1/1/30/32  single-port memory command.
REQ-015 mem_rdata  in  32  memory read data, valid exactly LATENCY cycles after mem_en.

Function
REQ-016 SHALL allow at most one outstanding transaction; states IDLE and BUSY.
REQ-017 In IDLE, with any request present, SHALL grant exactly one requester combinationally in that cycle, drive mem_en=1 and route its address, we and wdata to mem_*, then enter BUSY.
REQ-018 Fetch commands SHALL drive mem_we=0.
REQ-019 Priority: data SHALL win over fetch unless starve_cnt >= STARVE_MAX; in that case fetch SHALL win.
REQ-020 starve_cnt (3-bit, saturating) SHALL increment in every cycle where if_req=1 and d_gnt=1, and SHALL clear on if_gnt.
REQ-021 A latency counter SHALL load LATENCY-1 on grant and decrement in BUSY; the owner's rvalid SHALL pulse exactly LATENCY cycles after the grant cycle.
REQ-022 The owner's rdata SHALL equal mem_rdata in its rvalid cycle; rdata value is don't-care outside rvalid and for writes.
REQ-023 The non-owner's rvalid SHALL stay 0.
REQ-024 In the rvalid cycle the arbiter SHALL behave as IDLE, so a new grant may occur in that same cycle (throughput one transaction per LATENCY cycles).
REQ-025 With LATENCY=1, every cycle SHALL be able to grant, and rvalid SHALL follow in the next cycle.
REQ-026 Outside a grant cycle, if_gnt, d_gnt and mem_en SHALL be 0 and mem_we SHALL be 0.
REQ-027 Requests arriving while BUSY SHALL be ignored until eligible; no request is queued internally.
REQ-028 Simultaneous if_req and d_req in IDLE SHALL resolve in a single cycle per REQ-019; never both grants.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, starve_cnt=0, latency counter=0, owner=fetch.
REQ-030 During reset, all outputs (gnt, rvalid, mem_en, mem_we) SHALL be 0, and mem_addr, mem_wdata and rdata SHALL be 0.
REQ-031 Reset during BUSY SHALL drop the outstanding transaction; no rvalid for it SHALL ever appear.

Structure
REQ-032 Package mips_mem_pkg SHALL hold ADDR_W=30, DATA_W=32 and the owner type {OWN_IF, OWN_D}.
REQ-033 Implementation SHALL be a single flat module; no sub-module.

Verification
REQ-034 Lone fetch, LATENCY=2: if_req at T0, if_addr=0x10 -> if_gnt@T0, mem_addr=0x10, if_rvalid@T2 with if_rdata=mem_rdata.
REQ-035 Contention: if_req and d_req held continuously, STARVE_MAX=4 -> data granted 4 times, then fetch; starve_cnt returns to 0; pattern repeats.
REQ-036 Write: d_req, d_we=1, d_addr=0x3, d_wdata=0xDEADBEEF -> mem_we=1 with those values at grant, d_rvalid ack after LATENCY cycles, if_rvalid stays 0.
REQ-037 Back-to-back, LATENCY=1: d_req held 3 cycles -> d_gnt every cycle, d_rvalid in the next 3 cycles.
REQ-038 Reset mid-BUSY: grant at T0, rst_n low at T1 and released at T3 -> no rvalid at T2 or later; outputs 0 during reset.
REQ-039 Request while BUSY, LATENCY=3: fetch granted at T0, d_req raised at T1 -> d_gnt at T3 concurrent with if_rvalid.
